// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: sizes, major opcodes and the
// representable immediate ranges used by the field encoder.
package riscv_pkg;

    localparam int INST_SIZE = 32;
    localparam int DATA_SIZE = 32;

    typedef enum logic [6:0] {
        LOADS    = 7'h03,
        ALC_I    = 7'h13,
        AUIPC    = 7'h17,
        STORES   = 7'h23,
        ALC_R    = 7'h33,
        LUI      = 7'h37,
        BRANCHES = 7'h63,
        JALR     = 7'h67,
        JAL      = 7'h6F
    } t_opcode;

    // Branch and jump offsets are even, so their upper bounds stop one short.
    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    function automatic logic inRange(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational RV32I field packer: places register/funct fields and the
// immediate for each format and flags immediates the format cannot carry.
module instr_field_encoder
    import riscv_pkg::*;
#(
    parameter int INST_SIZE = riscv_pkg::INST_SIZE,
    parameter int DATA_SIZE = riscv_pkg::DATA_SIZE
) (
    input  t_opcode                      op_i,
    input  logic [4:0]                   rd_i,
    input  logic [4:0]                   rs1_i,
    input  logic [4:0]                   rs2_i,
    input  logic [2:0]                   funct3_i,
    input  logic [6:0]                   funct7_i,
    input  logic signed [DATA_SIZE-1:0]  imm_i,
    output logic [INST_SIZE-1:0]         instr_o,
    output logic                         rangeErr_o
);

    logic [6:0]  opBits;
    logic [31:0] immBits;
    int          immValue;
    logic [31:0] word;
    logic        err;

    assign opBits   = op_i;
    assign immBits  = 32'(imm_i);
    assign immValue = $signed(immBits);

    // Out-of-range immediates are still packed from their low bits; only the flag reports it.
    always_comb begin
        word = '0;
        err  = 1'b0;
        case (op_i)
            ALC_R: begin
                word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opBits};
            end
            LOADS, ALC_I, JALR: begin
                word = {immBits[11:0], rs1_i, funct3_i, rd_i, opBits};
                err  = !inRange(immValue, IMM_I_MIN, IMM_I_MAX);
            end
            STORES: begin
                word = {immBits[11:5], rs2_i, rs1_i, funct3_i, immBits[4:0], opBits};
                err  = !inRange(immValue, IMM_I_MIN, IMM_I_MAX);
            end
            BRANCHES: begin
                word = {immBits[12], immBits[10:5], rs2_i, rs1_i, funct3_i,
                        immBits[4:1], immBits[11], opBits};
                err  = !inRange(immValue, IMM_B_MIN, IMM_B_MAX) || immBits[0];
            end
            LUI, AUIPC: begin
                word = {immBits[31:12], rd_i, opBits};
                err  = (immBits[11:0] != 12'd0);
            end
            JAL: begin
                word = {immBits[20], immBits[10:1], immBits[11], immBits[19:12], rd_i, opBits};
                err  = !inRange(immValue, IMM_J_MIN, IMM_J_MAX) || immBits[0];
            end
            default: begin
                word = {25'd0, opBits};
                err  = 1'b1;
            end
        endcase
    end

    assign instr_o    = INST_SIZE'(word);
    assign rangeErr_o = err;

endmodule

// File: rtl/encode_and_pack.sv
// Accepts decoded instruction fields, encodes them into RV32I words and
// streams them out through a 2-entry FIFO, tagging each with a byte address.
module encode_and_pack
    import riscv_pkg::*;
#(
    parameter int INST_SIZE = riscv_pkg::INST_SIZE,
    parameter int DATA_SIZE = riscv_pkg::DATA_SIZE
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  t_opcode                      i_op,
    input  logic [4:0]                   i_rd,
    input  logic [4:0]                   i_rs1,
    input  logic [4:0]                   i_rs2,
    input  logic [2:0]                   i_funct3,
    input  logic [6:0]                   i_funct7,
    input  logic signed [DATA_SIZE-1:0]  i_immediate,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [INST_SIZE-1:0]         o_instr,
    output logic                         o_range_err,
    output logic [31:0]                  o_addr
);

    localparam int ENTRY_W = INST_SIZE + 1;

    logic [INST_SIZE-1:0] encInstr;
    logic                 encErr;

    logic [ENTRY_W-1:0]   mem_q [2];
    logic [ENTRY_W-1:0]   headEntry;
    logic                 wrPtr_q, wrPtr_d;
    logic                 rdPtr_q, rdPtr_d;
    logic [1:0]           count_q, count_d;
    logic [31:0]          addr_q, addr_d;
    logic                 push, pop;

    instr_field_encoder #(
        .INST_SIZE (INST_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) u_encoder (
        .op_i       (i_op),
        .rd_i       (i_rd),
        .rs1_i      (i_rs1),
        .rs2_i      (i_rs2),
        .funct3_i   (i_funct3),
        .funct7_i   (i_funct7),
        .imm_i      (i_immediate),
        .instr_o    (encInstr),
        .rangeErr_o (encErr)
    );

    // Both handshake flags come straight from the occupancy register, so
    // o_ready never combinationally depends on the downstream i_ready.
    assign o_valid = (count_q != 2'd0);
    assign o_ready = (count_q < 2'd2);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        addr_d  = addr_q;
        if (push) begin
            wrPtr_d = ~wrPtr_q;
        end
        if (pop) begin
            rdPtr_d = ~rdPtr_q;
            addr_d  = addr_q + 32'd4;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
            addr_q  <= 32'd0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            addr_q  <= addr_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q says so.
    always_ff @(posedge i_clk) begin
        if (push && !i_reset) begin
            mem_q[wrPtr_q] <= {encErr, encInstr};
        end
    end

    assign headEntry   = mem_q[rdPtr_q];
    assign o_instr     = o_valid ? headEntry[INST_SIZE-1:0] : '0;
    assign o_range_err = o_valid & headEntry[INST_SIZE];
    assign o_addr      = addr_q;

endmodule

// File: tb/tb_encode_and_pack.sv
// Self-checking bench for encode_and_pack: a queue-based reference model is
// compared against the DUT every cycle, plus literal directed expectations.
module tb_encode_and_pack;
    import riscv_pkg::*;

    logic                        i_clk = 1'b0;
    logic                        i_reset;
    logic                        i_valid;
    logic                        o_ready;
    t_opcode                     i_op;
    logic [4:0]                  i_rd, i_rs1, i_rs2;
    logic [2:0]                  i_funct3;
    logic [6:0]                  i_funct7;
    logic signed [DATA_SIZE-1:0] i_immediate;
    logic                        o_valid;
    logic                        i_ready;
    logic [INST_SIZE-1:0]        o_instr;
    logic                        o_range_err;
    logic [31:0]                 o_addr;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    typedef struct {
        logic [31:0] instr;
        bit          err;
        logic [6:0]  op;
        int          imm;
    } entry_t;

    entry_t      modelQ[$];
    logic [31:0] addrModel = 32'd0;

    encode_and_pack dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op        (i_op),
        .i_rd        (i_rd),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_funct3    (i_funct3),
        .i_funct7    (i_funct7),
        .i_immediate (i_immediate),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_instr     (o_instr),
        .o_range_err (o_range_err),
        .o_addr      (o_addr)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] place(input logic [31:0] v, input int lsb);
        return v << lsb;
    endfunction

    // Reference encoder: each field dropped at its RV32I bit position.
    function automatic void modelEncode(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input int imm, output logic [31:0] w, output bit e);
        logic [31:0] u;
        logic [31:0] regs;
        u    = imm;
        regs = place(rs1, 15) | place(f3, 12);
        e    = 1'b0;
        case (op)
            7'h33: w = place(f7, 25) | place(rs2, 20) | regs | place(rd, 7) | op;
            7'h03, 7'h13, 7'h67: begin
                w = place(u & 32'hFFF, 20) | regs | place(rd, 7) | op;
                e = (imm < -2048) || (imm > 2047);
            end
            7'h23: begin
                w = place((u >> 5) & 32'h7F, 25) | place(rs2, 20) | regs | place(u & 32'h1F, 7) | op;
                e = (imm < -2048) || (imm > 2047);
            end
            7'h63: begin
                w = place((u >> 12) & 1, 31) | place((u >> 5) & 32'h3F, 25) | place(rs2, 20) | regs
                    | place((u >> 1) & 32'hF, 8) | place((u >> 11) & 1, 7) | op;
                e = (imm < -4096) || (imm > 4094) || (u[0] == 1'b1);
            end
            7'h37, 7'h17: begin
                w = (u & 32'hFFFFF000) | place(rd, 7) | op;
                e = (u & 32'hFFF) != 0;
            end
            7'h6F: begin
                w = place((u >> 20) & 1, 31) | place((u >> 1) & 32'h3FF, 21) | place((u >> 11) & 1, 20)
                    | place((u >> 12) & 32'hFF, 12) | place(rd, 7) | op;
                e = (imm < -1048576) || (imm > 1048574) || (u[0] == 1'b1);
            end
            default: begin
                w = 32'(op);
                e = 1'b1;
            end
        endcase
    endfunction

    // Independent decoder: recovers the sign-extended immediate from a word.
    function automatic int decodeImm(input logic [31:0] w);
        logic [11:0] s;
        logic [12:0] b;
        logic [20:0] j;
        case (w[6:0])
            7'h03, 7'h13, 7'h67: return int'($signed(w[31:20]));
            7'h23: begin s = {w[31:25], w[11:7]}; return int'($signed(s)); end
            7'h63: begin b = {w[31], w[7], w[30:25], w[11:8], 1'b0}; return int'($signed(b)); end
            7'h37, 7'h17: return int'({w[31:12], 12'd0});
            7'h6F: begin j = {w[31], w[19:12], w[20], w[30:21], 1'b0}; return int'($signed(j)); end
            default: return 0;
        endcase
    endfunction

    // Model update: mirrors the accept/emit rules at every rising edge.
    always @(posedge i_clk) begin
        bit     doPop;
        bit     doPush;
        entry_t ent;
        if (i_reset) begin
            modelQ.delete();
            addrModel = 32'd0;
        end else begin
            doPop  = (modelQ.size() > 0) && i_ready;
            doPush = i_valid && (modelQ.size() < 2);
            if (doPop) begin
                modelQ.delete(0);
                addrModel = addrModel + 32'd4;
            end
            if (doPush) begin
                modelEncode(i_op, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, int'(i_immediate),
                            ent.instr, ent.err);
                ent.op  = i_op;
                ent.imm = int'(i_immediate);
                modelQ.push_back(ent);
            end
        end
    end

    always @(negedge i_clk) begin
        bit v;
        if (checkEn) begin
            v = modelQ.size() > 0;
            checkOutput("o_valid", o_valid, v);
            checkOutput("o_ready", o_ready, modelQ.size() < 2);
            checkOutput("o_addr", o_addr, addrModel);
            checkOutput("o_instr", o_instr, v ? modelQ[0].instr : 32'd0);
            checkOutput("o_range_err", o_range_err, v ? modelQ[0].err : 1'b0);
            if (v && !modelQ[0].err && modelQ[0].op != 7'h33) begin
                checkOutput("decode_imm", decodeImm(o_instr), modelQ[0].imm);
            end
        end
    end

    task automatic setFields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                             input int imm);
        i_op        = t_opcode'(op);
        i_rd        = rd;
        i_rs1       = rs1;
        i_rs2       = rs2;
        i_funct3    = f3;
        i_funct7    = f7;
        i_immediate = imm;
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input int imm);
        int n = 0;
        setFields(op, rd, rs1, rs2, f3, f7, imm);
        i_valid = 1'b1;
        while (!o_ready && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (!o_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: got o_ready=%b expected 1", o_ready);
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic pulseReset();
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
    endtask

    function automatic int randomImm(input logic [6:0] op, input bit legal);
        int edges[16] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095,
                          4096, 1048574, 1048575, 1048576, -1048576, -1048577, 32'h1000, 32'h1001};
        if (!legal) begin
            case ($urandom_range(0, 2))
                0:       return edges[$urandom_range(0, 15)];
                1:       return int'($urandom());
                default: return int'($urandom_range(0, 8191)) - 4096;
            endcase
        end
        case (op)
            7'h63:        return (int'($urandom_range(0, 4095)) - 2048) * 2;
            7'h6F:        return (int'($urandom_range(0, 1048575)) - 524288) * 2;
            7'h37, 7'h17: return int'($urandom() & 32'hFFFFF000);
            7'h33:        return int'($urandom());
            default:      return int'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    logic [6:0] opTable[12] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                                7'h63, 7'h67, 7'h6F, 7'h0B, 7'h7F, 7'h00};

    task automatic randomPhase(input int cycles, input bit legal);
        logic [6:0] op;
        for (int c = 0; c < cycles; c++) begin
            op = opTable[$urandom_range(0, legal ? 8 : 11)];
            setFields(op, 5'($urandom()), 5'($urandom()), 5'($urandom()),
                      3'($urandom()), 7'($urandom()), randomImm(op, legal));
            i_valid = 1'($urandom());
            i_ready = ($urandom_range(0, 3) != 0);
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        bit          e;

        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        setFields(7'h13, 0, 0, 0, 0, 0, 0);

        modelEncode(7'h23, 0, 3, 2, 3'b010, 0, -4, w, e);
        checkOutput("model_store", w, 32'hFE21AE23);
        modelEncode(7'h37, 5, 0, 0, 0, 0, 32'h12345000, w, e);
        checkOutput("model_lui", w, 32'h123452B7);
        modelEncode(7'h6F, 1, 0, 0, 0, 0, 2048, w, e);
        checkOutput("model_jal", w, 32'h001000EF);
        checkOutput("model_jal_err", e, 1'b0);
        modelEncode(7'h63, 0, 0, 0, 0, 0, 4095, w, e);
        checkOutput("model_branch_err", e, 1'b1);

        repeat (2) @(posedge i_clk);
        #1;
        checkEn = 1'b1;
        checkOutput("reset_valid", o_valid, 1'b0);
        checkOutput("reset_ready", o_ready, 1'b1);
        checkOutput("reset_addr", o_addr, 32'd0);
        i_reset = 1'b0;

        i_ready = 1'b1;
        applyStimulus(7'h13, 1, 0, 0, 0, 0, 5);
        checkOutput("addi_valid", o_valid, 1'b1);
        checkOutput("addi_instr", o_instr, 32'h00500093);
        checkOutput("addi_err", o_range_err, 1'b0);
        checkOutput("addi_addr", o_addr, 32'd0);
        applyStimulus(7'h6F, 1, 0, 0, 0, 0, 2048);
        checkOutput("jal_instr", o_instr, 32'h001000EF);
        checkOutput("jal_err", o_range_err, 1'b0);
        checkOutput("jal_addr", o_addr, 32'd4);
        applyStimulus(7'h63, 0, 0, 0, 0, 0, 4095);
        checkOutput("branch_4095_err", o_range_err, 1'b1);
        applyStimulus(7'h13, 0, 0, 0, 0, 0, 2048);
        checkOutput("addi_2048_err", o_range_err, 1'b1);
        checkOutput("addi_2048_instr", o_instr, 32'h80000013);
        applyStimulus(7'h0B, 3, 4, 5, 6, 7, 100);
        checkOutput("unsupported_err", o_range_err, 1'b1);
        checkOutput("unsupported_instr", o_instr, 32'h0000000B);
        repeat (3) @(posedge i_clk);
        #1;

        // Back-pressure: two words fill the FIFO, the third waits.
        pulseReset();
        i_ready = 1'b0;
        setFields(7'h13, 1, 0, 0, 0, 0, 5);
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        checkOutput("bp_ready_one", o_ready, 1'b1);
        setFields(7'h37, 5, 0, 0, 0, 0, 32'h12345000);
        @(posedge i_clk); #1;
        checkOutput("bp_ready_full", o_ready, 1'b0);
        setFields(7'h23, 0, 3, 2, 3'b010, 0, -4);
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("bp_still_full", o_ready, 1'b0);
        checkOutput("bp_word0", o_instr, 32'h00500093);
        checkOutput("bp_addr0", o_addr, 32'd0);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        checkOutput("bp_word1", o_instr, 32'h123452B7);
        checkOutput("bp_addr1", o_addr, 32'd4);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        checkOutput("bp_word2", o_instr, 32'hFE21AE23);
        checkOutput("bp_addr2", o_addr, 32'd8);
        @(posedge i_clk); #1;
        checkOutput("bp_drained", o_valid, 1'b0);

        // Reset while full, with handshakes offered on the same edge.
        i_ready = 1'b0;
        setFields(7'h13, 2, 1, 0, 0, 0, 7);
        i_valid = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("pre_reset_full", o_ready, 1'b0);
        i_ready = 1'b1;
        pulseReset();
        i_valid = 1'b0;
        i_ready = 1'b0;
        checkOutput("mid_reset_valid", o_valid, 1'b0);
        checkOutput("mid_reset_ready", o_ready, 1'b1);
        checkOutput("mid_reset_addr", o_addr, 32'd0);
        checkOutput("mid_reset_instr", o_instr, 32'd0);
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;

        randomPhase(400, 1'b1);
        randomPhase(400, 1'b0);

        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encode_and_pack.md
ENCODE_AND_PACK -- requirements
Module: encode_and_pack

Interface
REQ-001 SHALL have parameters INST_SIZE, default 32, instruction width; DATA_SIZE, default 32, immediate width (both from riscv_pkg).
REQ-002 SHALL have ports:
- i_clk  in  1  sole clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  input fields valid.
- o_ready  out  1  block can accept.
- i_op  in  t_opcode  opcode.
- i_rd, i_rs1, i_rs2  in  5 each  register indices.
- i_funct3  in  3  funct3.
- i_funct7  in  7  funct7.
- i_immediate  in  DATA_SIZE signed  immediate.
- o_valid  out  1  encoded word valid.
- i_ready  in  1  consumer accepts.
- o_instr  out  INST_SIZE  encoded instruction.
- o_range_err  out  1  immediate unrepresentable or op unsupported.
- o_addr  out  32  byte address of the word at the output.
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 Input handshake SHALL occur when i_valid && o_ready at a rising edge; output handshake when o_valid && i_ready.
REQ-005 Accepted fields SHALL be encoded combinationally and stored with their error flag in a 2-entry in-order FIFO; o_instr/o_range_err/o_addr SHALL come from the head entry.
REQ-006 Latency: word accepted into an empty FIFO at edge N SHALL show o_valid=1 in the cycle after edge N.
REQ-007 o_ready SHALL equal (count < 2), derived from registers only, independent of i_ready.
REQ-008 Simultaneous push and pop SHALL leave count unchanged, including at count=2 (no push, since o_ready=0) and count=0 (no pop).
REQ-009 o_instr[6:0] SHALL be the t_opcode value; field placement per RV32I: R (ALC_R): funct7,rs2,rs1,funct3,rd; I (LOADS, ALC_I, JALR): imm[11:0],rs1,funct3,rd; S (STORES): imm[11:5],rs2,rs1,funct3,imm[4:0]; B (BRANCHES): imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11]; U (LUI, AUIPC): imm[31:12],rd; J (JAL): imm[20],imm[10:1],imm[11],imm[19:12],rd.
REQ-010 o_range_err SHALL be 1 when: I/S imm outside [-2048, 2047]; B imm outside [-4096, 4094] or imm[0]=1; J imm outside [-1048576, 1048574] or imm[0]=1; U imm[11:0] != 0; op not listed in REQ-009. ALC_R SHALL never flag.
REQ-011 On range error the word SHALL still be emitted, encoded from truncated immediate bits; unsupported op SHALL emit opcode field with all other bits 0.
REQ-012 o_addr SHALL increment by 4 on each output handshake, wrapping 32'hFFFF_FFFC -> 0.
REQ-013 While o_valid=0, o_instr and o_range_err SHALL be 0.

Reset
REQ-014 When i_reset=1 at an edge: count=0, o_valid=0, o_ready=1 next cycle, o_addr=0, o_instr=0, o_range_err=0; FIFO contents discarded, including mid-transfer.
REQ-015 Handshakes coincident with reset SHALL be ignored.

Structure
REQ-016 riscv_pkg SHALL hold INST_SIZE, DATA_SIZE, t_opcode (LOADS 7'h03, ALC_I 7'h13, AUIPC 7'h17, STORES 7'h23, ALC_R 7'h33, LUI 7'h37, BRANCHES 7'h63, JALR 7'h67, JAL 7'h6F) and the immediate range constants.
REQ-017 Encoding and range check SHALL be one combinational sub-module, instr_field_encoder; FIFO, counter and handshake logic remain in encode_and_pack.

Verification
REQ-018 ALC_I rd=1 rs1=0 funct3=0 imm=5, i_ready=1 -> o_instr=32'h00500093, err=0, o_addr=0, one cycle after accept.
REQ-019 STORES rs1=3 rs2=2 funct3=3'b010 imm=-4 -> 32'hFE21AE23; LUI rd=5 imm=32'h12345000 -> 32'h123452B7.
REQ-020 JAL rd=1 imm=2048 -> 32'h001000EF, err=0; BRANCHES imm=4095 -> err=1; ALC_I imm=2048 -> err=1.
REQ-021 i_ready=0, three back-to-back pushes -> o_ready=0 after second accept, third held; i_ready=1 -> three words in order with o_addr 0, 4, 8.
REQ-022 Count=2 with reset asserted one cycle -> next cycle o_valid=0, o_ready=1, o_addr=0; no stale word emitted.
REQ-023 Random legal fields -> immediate decoded by decode_and_extend from o_instr equals i_immediate, err=0 throughout.
